aes_key_expand_128: RTL and testbench

Iterative AES-128 key schedule that sits directly upstream of the AES encrypt/decrypt core. It accepts a 128-bit cipher key and generates the 11 round keys, one per clock. It stores them in a register bank and serves any round key through a random-access read port. The encrypt path reads round keys 0..10 and the decrypt path reads 10..0, so both directions share one expansion.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_sub_word.sv | 12 +
 rtl/aes_key_expand_128.sv | 127 ++++++++++++
 tb/tb_aes_key_expand_128.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) doubling, round count and key-schedule state.
package aes_pkg;

  localparam int NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_e;

  // Byte b sits at bits [2047-8*b -: 8]; row r holds entries 16r..16r+15.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry bank
// with a combinational random-access read port shared by encrypt and decrypt.
//
// Handshake: start is a one-cycle request accepted only while busy=0 (IDLE); once
// accepted busy stays high for NR cycles, done pulses for one cycle as busy falls,
// and key_valid holds from then until the next accepted start or reset.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rk_sel,
  output logic [127:0] rk_out
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         key_valid_q, key_valid_d;
  logic [127:0] bank_q [0:NR];
  logic [127:0] bank_d [0:NR];

  logic [3:0]   prev_idx;
  logic [127:0] prev_rk;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0, w1, w2, w3;

  assign prev_idx = round_q - 4'd1;

  always_comb begin
    prev_rk = '0;
    for (int i = 0; i <= NR; i++) begin
      if (prev_idx == 4'(i)) prev_rk = bank_q[i];
    end
  end

  assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

  aes_sub_word u_sub_word (
    .word_in  (rot_word),
    .word_out (sub_word)
  );

  assign w0 = prev_rk[127:96] ^ sub_word ^ {rcon_q, 24'h0};
  assign w1 = prev_rk[95:64]  ^ w0;
  assign w2 = prev_rk[63:32]  ^ w1;
  assign w3 = prev_rk[31:0]   ^ w2;

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    bank_d      = bank_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          bank_d[0]   = key_in;
          round_d     = 4'd1;
          rcon_d      = RCON_INIT;
          key_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (round_q == 4'(i)) bank_d[i] = {w0, w1, w2, w3};
        end
        rcon_d  = xtime(rcon_q);
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          round_d     = 4'd0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      rcon_q      <= RCON_INIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      bank_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      bank_q      <= bank_d;
    end
  end

  // Indices 11..15 have no bank entry and read as zero.
  always_comb begin
    rk_out = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_sel == 4'(i)) rk_out = bank_q[i];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128: known-answer keys, random keys
// against a word-level FIPS-197 key-schedule model with a field-derived S-box.
module tb_aes_key_expand_128;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rk_sel;
  logic [127:0] rk_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_key_expand_128 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rk_sel    (rk_sel),
    .rk_out    (rk_out)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Reference model: S-box from GF(2^8) inversion plus affine map
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x};
    return t[15 - n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // Driver: start an expansion and track the control outputs until done
  task automatic run_expansion(input string tag, input logic [127:0] key,
                               input int inject_at, input bit scramble);
    int edges, busy_cycles, done_pulses;
    bit overlap, kv_dropped;
    expand_model(key);
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
    @(negedge clk);
    start       = 1'b0;
    edges       = 1;
    busy_cycles = busy ? 1 : 0;
    kv_dropped  = !key_valid;
    overlap     = done && busy;
    done_pulses = 0;
    while (!done && edges < 40) begin
      if (inject_at == edges) begin
        start  = 1'b1;
        key_in = '0;
      end else begin
        start = 1'b0;
      end
      if (scramble) key_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      edges++;
      if (busy) busy_cycles++;
      if (done && busy) overlap = 1'b1;
    end
    start = 1'b0;
    if (done) done_pulses = 1;
    check({tag, "_latency"}, 128'(edges), 128'd11);
    check({tag, "_kv_after_done"}, 128'(key_valid), 128'd1);
    check({tag, "_busy_low_at_done"}, 128'(busy), 128'd0);
    repeat (3) begin
      @(negedge clk);
      if (done) done_pulses++;
      if (done && busy) overlap = 1'b1;
    end
    check({tag, "_done_pulses"}, 128'(done_pulses), 128'd1);
    check({tag, "_busy_cycles"}, 128'(busy_cycles), 128'd10);
    check({tag, "_kv_dropped"}, 128'(kv_dropped), 128'd1);
    check({tag, "_done_busy_overlap"}, 128'(overlap), 128'd0);
  endtask

  // Scoreboard: read every round key back and compare against the model
  task automatic read_check(input string tag);
    logic [127:0] exp;
    for (int r = 0; r < 11; r++) begin
      rk_sel = 4'(r);
      #1;
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd1);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("%s_rk%0d", tag, r), rk_out, exp);
      end
    end
  endtask

  task automatic read_one(input string tag, input int sel, input logic [127:0] exp);
    rk_sel = 4'(sel);
    #1;
    check(tag, rk_out, exp);
  endtask

  initial begin
    logic [127:0] rkey;
    bit           seen;

    build_sbox();
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    rk_sel = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_key_valid", 128'(key_valid), 128'd0);
    read_one("rst_rk0", 0, 128'h0);
    read_one("rst_rk10", 10, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Codebase key
    run_expansion("keyA", KEY_A, 0, 1'b0);
    read_check("keyA");
    read_one("keyA_kat_rk0", 0, KEY_A);
    read_one("keyA_kat_rk10", 10, A_RK10);

    // Re-key with the FIPS-197 key while key_valid=1
    run_expansion("rekeyB", KEY_B, 0, 1'b0);
    read_check("rekeyB");
    read_one("keyB_kat_rk1", 1, B_RK1);
    read_one("keyB_kat_rk10", 10, B_RK10);

    // Start pulse while busy must be ignored
    run_expansion("busy_start", KEY_B, 5, 1'b0);
    read_check("busy_start");
    read_one("busy_start_kat_rk10", 10, B_RK10);

    // Out-of-range selects
    read_one("sel11_zero", 11, 128'h0);
    read_one("sel15_zero", 15, 128'h0);

    // Random keys, half with key_in changing after capture
    for (int k = 0; k < 6; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_expansion($sformatf("rand%0d", k), rkey, (k == 2) ? $urandom_range(1, 9) : 0, k[0]);
      read_check($sformatf("rand%0d", k));
    end

    // Asynchronous reset in the middle of an expansion
    @(negedge clk);
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_key_valid", 128'(key_valid), 128'd0);
    for (int s = 0; s < 16; s++) read_one($sformatf("midrst_rk%0d", s), s, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", 128'(seen), 128'd0);

    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_expansion("post_rst", rkey, 0, 1'b0);
    read_check("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
